// File: rtl/sccb_cfg_seq.sv
// sccb_cfg_seq: walks a fixed camera register table through an SCCB write engine.
// Define CFG_SOFTRST_DELAY_EN to insert a settle delay after the entry-0 soft reset.
module sccb_cfg_seq #(
  parameter int TBL_LEN     = 8,
  parameter int DELAY_CYC   = 1000000,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_go,
  output logic       o_wr_req,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  input  logic       i_wr_ack,
  input  logic       i_wr_done,
  output logic       o_busy,
  output logic       o_cfg_done,
  output logic       o_cfg_err,
  output logic [3:0] o_entry_idx
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DELAY = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
  localparam int CNT_MAX = (DELAY_CYC > TIMEOUT_CYC) ? DELAY_CYC : TIMEOUT_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_HIT  = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] DLY_END = CW'(DELAY_CYC - 1);
  localparam logic [3:0] IDX_LAST = 4'(TBL_LEN - 1);
  logic [2:0]    r_state;
  logic          r_go_q;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_idx;
  logic [7:0]    r_addr;
  logic [7:0]    r_data;
  logic          w_start;
  logic [3:0]    w_nxt_idx;
  function automatic logic [15:0] tbl(input logic [3:0] i);
    case (i)
      4'd0:    tbl = 16'h1280;
      4'd1:    tbl = 16'h1204;
      4'd2:    tbl = 16'h1101;
      4'd3:    tbl = 16'h40D0;
      4'd4:    tbl = 16'h8C00;
      4'd5:    tbl = 16'h3A04;
      4'd6:    tbl = 16'h0C00;
      4'd7:    tbl = 16'h3E00;
      default: tbl = 16'h0000;
    endcase
  endfunction
  assign w_start     = i_go & ~r_go_q;
  assign w_nxt_idx   = r_idx + 4'd1;
  assign o_wr_req    = r_state == S_REQ;
  assign o_busy      = r_state == S_REQ || r_state == S_WAIT || r_state == S_DELAY;
  assign o_cfg_done  = r_state == S_DONE;
  assign o_cfg_err   = r_state == S_ERR;
  assign o_wr_addr   = r_addr;
  assign o_wr_data   = r_data;
  assign o_entry_idx = r_idx;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_go_q  <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_go_q <= i_go;
      case (r_state)
        S_IDLE, S_DONE, S_ERR:
          if (w_start) begin
            r_state         <= S_REQ;
            r_idx           <= '0;
            {r_addr, r_data} <= tbl(4'd0);
          end
        S_REQ:
          if (i_wr_ack) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
        S_WAIT:
          // a done pulse arriving in the timeout cycle still counts as success
          if (i_wr_done) begin
            if (r_idx == IDX_LAST) r_state <= S_DONE;
            else begin
              r_idx           <= w_nxt_idx;
              {r_addr, r_data} <= tbl(w_nxt_idx);
              r_cnt           <= '0;
`ifdef CFG_SOFTRST_DELAY_EN
              r_state         <= (r_idx == 4'd0) ? S_DELAY : S_REQ;
`else
              r_state         <= S_REQ;
`endif
            end
          end else if (r_cnt + CW'(1) == TO_HIT) r_state <= S_ERR;
          else r_cnt <= r_cnt + CW'(1);
        S_DELAY:
          if (r_cnt == DLY_END) r_state <= S_REQ;
          else r_cnt <= r_cnt + CW'(1);
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sccb_cfg_seq.sv
// tb_sccb_cfg_seq: scoreboard bench for sccb_cfg_seq with a simple engine model
// (ack 2 cycles after request, done 10 cycles after ack).
module tb_sccb_cfg_seq;
  logic clock = 1'b0;
  logic reset, go, wr_ack, wr_done;
  logic wr_req, busy, cfg_done, cfg_err;
  logic [7:0] wr_addr, wr_data;
  logic [3:0] entry_idx;
  localparam logic [15:0] TBL [8] = '{16'h1280, 16'h1204, 16'h1101, 16'h40D0,
                                      16'h8C00, 16'h3A04, 16'h0C00, 16'h3E00};
`ifdef CFG_SOFTRST_DELAY_EN
  localparam int EXP_GAP = 21;
`else
  localparam int EXP_GAP = 1;
`endif
  int checks = 0, errors = 0, cyc = 0;
  int withhold_idx = -1, ack_cyc3 = 0, done_cyc0 = 0, go_cyc = 0;
  bit spur = 0, gap_chk = 0, lat_chk = 0, prev_req = 0, prev_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur_exp = '0;
  sccb_cfg_seq #(.TBL_LEN(8), .DELAY_CYC(20), .TIMEOUT_CYC(50)) dut (
    .clock(clock), .reset(reset), .i_go(go), .o_wr_req(wr_req),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .i_wr_ack(wr_ack),
    .i_wr_done(wr_done), .o_busy(busy), .o_cfg_done(cfg_done),
    .o_cfg_err(cfg_err), .o_entry_idx(entry_idx)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  task automatic push(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(TBL[i]);
  endtask
  task automatic pulse_go();
    @(negedge clock); go = 1'b1; go_cyc = cyc;
    @(negedge clock); go = 1'b0;
  endtask
  task automatic wait_end(input int lim);
    for (int i = 0; i < lim && !(cfg_done || cfg_err); i++) @(negedge clock);
    check("end_reached", int'(cfg_done | cfg_err), 1);
  endtask
  // engine model; a request may also be met by a stray done pulse when spur is set
  initial begin : engine
    int st, cnt;
    st = 0; cnt = 0; wr_ack = 1'b0; wr_done = 1'b0;
    forever begin
      @(negedge clock);
      wr_ack = 1'b0; wr_done = 1'b0;
      if (reset) st = 0;
      else if (st == 0) begin
        if (wr_req) begin st = 1; wr_done = spur; end
      end else if (st == 1) begin
        wr_ack = 1'b1; st = 2; cnt = 0;
        if (entry_idx == 4'd3) ack_cyc3 = cyc;
      end else begin
        cnt++;
        if (cnt == 10) begin
          st = 0;
          if (int'(entry_idx) != withhold_idx) begin
            wr_done = 1'b1;
            if (entry_idx == 4'd0) done_cyc0 = cyc;
          end
        end
      end
    end
  end
  always @(negedge clock) begin
    if (wr_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got %h%h expected none", wr_addr, wr_data);
      end else begin
        cur_exp = exp_q.pop_front();
        check("req_order", int'({wr_addr, wr_data}), int'(cur_exp));
      end
      if (lat_chk && entry_idx == 4'd0) check("go_to_req", cyc - go_cyc, 1);
      if (gap_chk && entry_idx == 4'd1) check("softrst_gap", cyc - done_cyc0, EXP_GAP);
    end else if (wr_req) check("req_stable", int'({wr_addr, wr_data}), int'(cur_exp));
    if (cfg_err && !prev_err) check("timeout_lat", cyc - ack_cyc3, 50);
    prev_req = wr_req;
    prev_err = cfg_err;
  end
  initial begin
    reset = 1'b1; go = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_req", int'(wr_req), 0);
    check("rst_addr", int'(wr_addr), 0);
    check("rst_data", int'(wr_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(cfg_done), 0);
    check("rst_err", int'(cfg_err), 0);
    check("rst_idx", int'(entry_idx), 0);
    reset = 1'b0;
    @(negedge clock);
    push(8); gap_chk = 1; lat_chk = 1;
    pulse_go();
    check("busy_run", int'(busy), 1);
    wait_end(600);
    gap_chk = 0; lat_chk = 0;
    check("t1_done", int'(cfg_done), 1);
    check("t1_err", int'(cfg_err), 0);
    check("t1_busy", int'(busy), 0);
    check("t1_idx", int'(entry_idx), 7);
    check("t1_q_empty", exp_q.size(), 0);
    repeat (5) @(negedge clock);
    check("t1_hold", int'({wr_addr, wr_data}), 16'h3E00);
    withhold_idx = 3; push(4);
    pulse_go();
    wait_end(600);
    check("t2_err", int'(cfg_err), 1);
    check("t2_done", int'(cfg_done), 0);
    check("t2_idx", int'(entry_idx), 3);
    check("t2_busy", int'(busy), 0);
    repeat (30) @(negedge clock);
    check("t2_no_req", int'(wr_req), 0);
    check("t2_q_empty", exp_q.size(), 0);
    withhold_idx = -1; spur = 1; push(8);
    pulse_go();
    for (int i = 0; i < 600 && !cfg_done && !cfg_err; i++) begin
      @(negedge clock);
      go = busy && entry_idx < 4'd6 && (i % 9 < 3);
    end
    go = 1'b0; spur = 0;
    check("t3_done", int'(cfg_done), 1);
    check("t3_err", int'(cfg_err), 0);
    check("t3_idx", int'(entry_idx), 7);
    check("t3_q_empty", exp_q.size(), 0);
    push(6);
    pulse_go();
    for (int i = 0; i < 600 && !(entry_idx == 4'd5 && !wr_req && busy); i++) @(negedge clock);
    check("t4_in_wait5", int'(entry_idx == 4'd5 && !wr_req && busy), 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t4_rst_req", int'(wr_req), 0);
    check("t4_rst_idx", int'(entry_idx), 0);
    check("t4_rst_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    check("t4_q_empty", exp_q.size(), 0);
    repeat (5) @(negedge clock);
    check("t4_no_resume", int'(wr_req | busy), 0);
    push(8);
    pulse_go();
    wait_end(600);
    check("t4_done", int'(cfg_done), 1);
    check("t4_idx", int'(entry_idx), 7);
    check("t4_q_empty2", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sccb_cfg_seq.md
SCCB_CFG_SEQ -- requirements
Module: sccb_cfg_seq

Interface
REQ-001 Parameter TBL_LEN, default 8, is the number of register-write entries in the internal table.
REQ-002 Parameter DELAY_CYC, default 1000000, is the post-soft-reset settle time in clock cycles (10 ms at 100 MHz).
REQ-003 Parameter TIMEOUT_CYC, default 100000, is the maximum number of cycles from wr_ack to wr_done.
REQ-004 clock  input  1  100 MHz system clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 go  input  1  rising edge starts a full table pass.
REQ-007 wr_req  output  1  write request to the downstream SCCB write engine.
REQ-008 wr_addr  output  8  camera register sub-address of the current entry.
REQ-009 wr_data  output  8  value to write to that register.
REQ-010 wr_ack  input  1  engine accepted the request; sampled only while wr_req=1.
REQ-011 wr_done  input  1  single-cycle pulse: engine finished the transaction (stop condition complete).
REQ-012 busy  output  1  high from leaving IDLE until DONE or ERR is reached.
REQ-013 cfg_done  output  1  high while in DONE.
REQ-014 cfg_err  output  1  high while in ERR.
REQ-015 entry_idx  output  4  index of the current or last entry.

Function
REQ-016 Table contents, index:addr/data: 0:12/80, 1:12/04, 2:11/01, 3:40/D0, 4:8C/00, 5:3A/04, 6:0C/00, 7:3E/00.
REQ-017 The states SHALL be IDLE, REQ, WAIT, DELAY, DONE and ERR.
REQ-018 go edge detection SHALL use a registered copy of go: start = go & ~go_q.
REQ-019 IDLE, DONE or ERR with start -> REQ, with entry_idx=0 and cfg_done/cfg_err cleared on the next cycle.
REQ-020 In REQ, wr_req=1 and wr_addr/wr_data SHALL be held stable until wr_ack=1 is sampled; next state is WAIT and wr_req=0 on the following cycle.
REQ-021 In WAIT, a cycle counter SHALL count from 0.
- wr_done=1 -> advance.
- Counter reaching TIMEOUT_CYC-1 without wr_done -> ERR; entry_idx retains the failing index.
REQ-022 Advance rule:
- entry_idx=TBL_LEN-1 -> DONE.
- Otherwise entry_idx increments and the next state is REQ (or DELAY, per REQ-031).
REQ-023 wr_done outside WAIT and wr_ack outside REQ SHALL be ignored.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 wr_done and a timeout in the same cycle: wr_done wins.
REQ-026 Latency from start to the first wr_req SHALL be exactly 1 cycle; from wr_done to the next wr_req, 1 cycle when no delay applies.
REQ-027 Counter width SHALL be sufficient for max(DELAY_CYC, TIMEOUT_CYC) with no wrap; entry_idx SHALL never exceed TBL_LEN-1.

Reset
REQ-028 reset SHALL force IDLE, wr_req=0, wr_addr=00, wr_data=00, busy=0, cfg_done=0, cfg_err=0, entry_idx=0, counter=0, go_q=0.
REQ-029 reset asserted mid-transaction SHALL drop wr_req on the next edge; the sequence does not resume without a new go edge.
REQ-030 In IDLE, wr_addr and wr_data SHALL hold their last values.

Configuration
REQ-031 With macro CFG_SOFTRST_DELAY_EN defined, completion of entry 0 (COM7=80, soft reset) SHALL enter DELAY for exactly DELAY_CYC cycles, then REQ for entry 1.
REQ-032 Without CFG_SOFTRST_DELAY_EN, DELAY SHALL be unreachable and entry 0 SHALL advance like any other entry.

Verification (DELAY_CYC=20, TIMEOUT_CYC=50, engine model acks after 2 cycles and pulses done 10 cycles after ack)
REQ-033 Reset, pulse go -> 8 requests in order 12/80, 12/04, 11/01, 40/D0, 8C/00, 3A/04, 0C/00, 3E/00; cfg_done=1, busy=0.
REQ-034 CFG_SOFTRST_DELAY_EN defined -> gap from entry-0 wr_done to entry-1 wr_req = 21 cycles; undefined -> 1 cycle.
REQ-035 Model withholds wr_done for entry 3 -> cfg_err=1 exactly 50 cycles after ack; entry_idx=3; no further wr_req.
REQ-036 go pulsed while busy plus a spurious wr_done during REQ -> no restart, no skipped entry; sequence identical to REQ-033.
REQ-037 reset asserted while in WAIT on entry 5 -> wr_req=0, entry_idx=0, state IDLE next cycle; a new go restarts from 12/80.
